// File: rtl/control_fsm.sv
// Fetch/decode/execute sequencer for the 16-bit ISA; Moore outputs, 3-cycle ops (LOAD 4).
// No backpressure: advances every cycle; Reset forces INIT and drops write strobes at once.
module control_fsm #(
    parameter int IW  = 16,
    parameter int DAW = 8,
    parameter int RAW = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [IW-1:0]  inst,
    output logic           PC_clr,
    output logic           PC_up,
    output logic           IR_ld,
    output logic [DAW-1:0] D_addr,
    output logic           D_wr,
    output logic           RF_s,
    output logic [RAW-1:0] RF_W_addr,
    output logic           RF_W_en,
    output logic [RAW-1:0] RF_Ra_addr,
    output logic [RAW-1:0] RF_Rb_addr,
    output logic [2:0]     ALU_s0,
    output logic [3:0]     state_out
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t state_q, state_d, state_cur;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        // Decode from INIT while Reset is high so strobes drop without waiting on the flop.
        state_cur  = Reset ? S_INIT : state_q;
        state_d    = S_INIT;
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = 3'b000;
        case (state_cur)
            S_INIT: begin
                PC_clr  = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                IR_ld   = 1'b1;
                PC_up   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (inst[15:12])
                    4'b0001: state_d = S_STORE;
                    4'b0010: state_d = S_LOAD_A;
                    4'b0011: state_d = S_ADD;
                    4'b0100: state_d = S_SUB;
                    4'b0101: state_d = S_HALT;
                    default: state_d = S_NOOP;
                endcase
            end
            S_NOOP: state_d = S_FETCH;
            S_LOAD_A: begin
                D_addr    = inst[11:4];
                RF_s      = 1'b1;
                RF_W_addr = inst[3:0];
                state_d   = S_LOAD_B;
            end
            S_LOAD_B: begin
                D_addr    = inst[11:4];
                RF_s      = 1'b1;
                RF_W_addr = inst[3:0];
                RF_W_en   = 1'b1;
                state_d   = S_FETCH;
            end
            S_STORE: begin
                D_addr     = inst[7:0];
                RF_Ra_addr = inst[11:8];
                D_wr       = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = inst[11:8];
                RF_Rb_addr = inst[7:4];
                RF_W_addr  = inst[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state_cur == S_ADD) ? 3'b001 : 3'b010;
                state_d    = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    assign state_out = state_cur;

endmodule
